// File: rtl/fwd_scoreboard_if.sv
// Issue, operand-source and forwarding-result bundle of the forwarding scoreboard.
// All buses are MSB-first ([0:N-1]); flattened fields place pipe/operand 0 at the lowest indices.
interface fwd_scoreboard_if #(
  parameter int NUM_PIPES = 2,
  parameter int DEPTH     = 7,
  parameter int NUM_SRC   = 3,
  parameter int REG_AW    = 7,
  parameter int LAT_W     = 4,
  parameter int CNT_W     = 16
);
  localparam int PW  = (NUM_PIPES > 1) ? $clog2(NUM_PIPES) : 1;
  localparam int SW  = $clog2(DEPTH + 1);
  localparam int NOP = NUM_PIPES * NUM_SRC;

  // Handshake: issue_valid[p] is taken on a clock edge only if stall=0 and flush=0 on that
  // edge; stall acts as the inverted ready, and a refused issue must be re-presented by upstream.
  logic [0:NUM_PIPES-1]        issue_valid;
  logic [0:NUM_PIPES-1]        issue_wr;
  logic [0:NUM_PIPES*REG_AW-1] issue_dst;
  logic [0:NUM_PIPES*LAT_W-1]  issue_lat;
  logic [0:NOP-1]              src_valid;
  logic [0:NOP*REG_AW-1]       src_reg;
  logic                        flush;
  logic [0:NOP-1]              fwd_hit;
  logic [0:NOP*PW-1]           fwd_pipe;
  logic [0:NOP*SW-1]           fwd_stage;
  logic                        stall;
  logic [CNT_W-1:0]            stall_cnt;

  modport master (
    output issue_valid, issue_wr, issue_dst, issue_lat, src_valid, src_reg, flush,
    input  fwd_hit, fwd_pipe, fwd_stage, stall, stall_cnt
  );

  modport slave (
    input  issue_valid, issue_wr, issue_dst, issue_lat, src_valid, src_reg, flush,
    output fwd_hit, fwd_pipe, fwd_stage, stall, stall_cnt
  );
endinterface

// File: rtl/fwd_scoreboard.sv
// In-flight result tracker with youngest-producer operand forwarding and RAW stall.
// Each pipe keeps a DEPTH-stage shift register of {valid, wr, dst, lat}; stage 1 is the youngest.
module fwd_scoreboard #(
  parameter int NUM_PIPES = 2,
  parameter int DEPTH     = 7,
  parameter int NUM_SRC   = 3,
  parameter int REG_AW    = 7,
  parameter int LAT_W     = 4,
  parameter int CNT_W     = 16
) (
  input logic             clk,
  input logic             reset_n,
  fwd_scoreboard_if.slave bus
);
  localparam int PW  = (NUM_PIPES > 1) ? $clog2(NUM_PIPES) : 1;
  localparam int SW  = $clog2(DEPTH + 1);
  localparam int NOP = NUM_PIPES * NUM_SRC;

  typedef struct packed {
    logic              valid;
    logic              wr;
    logic [REG_AW-1:0] dst;
    logic [LAT_W-1:0]  lat;
  } entry_t;

  entry_t            ent [NUM_PIPES][1:DEPTH];
  logic [0:NOP-1]    hit;
  logic [0:NOP*PW-1] pipe_sel;
  logic [0:NOP*SW-1] stage_sel;
  logic              stall;
  logic [CNT_W-1:0]  stall_cnt;

  // The tracker never freezes: stalled issues become bubbles, and flush only
  // kills the two youngest stages since stage 3 onward is committed.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int p = 0; p < NUM_PIPES; p++) begin
        for (int k = 1; k <= DEPTH; k++) begin
          ent[p][k] <= '0;
        end
      end
    end else begin
      for (int p = 0; p < NUM_PIPES; p++) begin
        ent[p][1].valid <= bus.issue_valid[p] & ~stall & ~bus.flush;
        ent[p][1].wr    <= bus.issue_wr[p];
        ent[p][1].dst   <= bus.issue_dst[p*REG_AW +: REG_AW];
        ent[p][1].lat   <= bus.issue_lat[p*LAT_W +: LAT_W];
        for (int k = 1; k < DEPTH; k++) begin
          ent[p][k+1] <= ent[p][k];
          if (bus.flush && k <= 2) ent[p][k+1].valid <= 1'b0;
        end
      end
    end
  end

  // Youngest match wins (lowest stage, then highest pipe); older matches are
  // shadowed even when ready so a later writer to the same register is never bypassed.
  always_comb begin : select
    logic found;
    logic ready;
    int   sel_q;
    int   sel_k;
    found     = 1'b0;
    ready     = 1'b0;
    sel_q     = 0;
    sel_k     = 0;
    hit       = '0;
    pipe_sel  = '0;
    stage_sel = '0;
    stall     = 1'b0;
    for (int o = 0; o < NOP; o++) begin
      found = 1'b0;
      ready = 1'b0;
      sel_q = 0;
      sel_k = 0;
      for (int k = 1; k <= DEPTH; k++) begin
        for (int q = NUM_PIPES - 1; q >= 0; q--) begin
          if (!found && bus.src_valid[o] && ent[q][k].valid && ent[q][k].wr &&
              ent[q][k].dst == bus.src_reg[o*REG_AW +: REG_AW]) begin
            found = 1'b1;
            sel_q = q;
            sel_k = k;
            ready = (int'(ent[q][k].lat) <= k);
          end
        end
      end
      if (found && ready) begin
        hit[o]                = 1'b1;
        pipe_sel[o*PW +: PW]  = PW'(sel_q);
        stage_sel[o*SW +: SW] = SW'(sel_k);
      end
      if (found && !ready) stall = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt <= '0;
    end else if (stall && stall_cnt != '1) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

  assign bus.fwd_hit   = hit;
  assign bus.fwd_pipe  = pipe_sel;
  assign bus.fwd_stage = stage_sel;
  assign bus.stall     = stall;
  assign bus.stall_cnt = stall_cnt;
endmodule

// File: tb/tb_fwd_scoreboard.sv
// Bench for fwd_scoreboard: directed scenarios plus random traffic against a
// record-list model of in-flight producers.
module tb_fwd_scoreboard;
  localparam int NUM_PIPES = 2;
  localparam int DEPTH     = 7;
  localparam int NUM_SRC   = 3;
  localparam int REG_AW    = 7;
  localparam int LAT_W     = 4;
  localparam int CNT_W     = 10;
  localparam int PW        = (NUM_PIPES > 1) ? $clog2(NUM_PIPES) : 1;
  localparam int SW        = $clog2(DEPTH + 1);
  localparam int NOP       = NUM_PIPES * NUM_SRC;
  localparam int CNT_MAX   = (1 << CNT_W) - 1;

  logic clk;
  logic reset_n;
  int   n_checks;
  int   n_fail;

  fwd_scoreboard_if #(.NUM_PIPES(NUM_PIPES), .DEPTH(DEPTH), .NUM_SRC(NUM_SRC),
                      .REG_AW(REG_AW), .LAT_W(LAT_W), .CNT_W(CNT_W)) bus ();

  fwd_scoreboard #(.NUM_PIPES(NUM_PIPES), .DEPTH(DEPTH), .NUM_SRC(NUM_SRC),
                   .REG_AW(REG_AW), .LAT_W(LAT_W), .CNT_W(CNT_W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  typedef struct {
    int pipe;
    int dst;
    int lat;
    int stage;
  } rec_t;

  rec_t recs[$];
  int   m_cnt;
  bit   exp_hit[NOP];
  int   exp_pipe[NOP];
  int   exp_stage[NOP];
  bit   exp_stall;

  function automatic void model_eval();
    int best;
    exp_stall = 1'b0;
    for (int o = 0; o < NOP; o++) begin
      exp_hit[o]   = 1'b0;
      exp_pipe[o]  = 0;
      exp_stage[o] = 0;
      best = -1;
      if (bus.src_valid[o] === 1'b1) begin
        foreach (recs[i]) begin
          if (recs[i].dst == int'(bus.src_reg[o*REG_AW +: REG_AW])) begin
            if (best < 0 || recs[i].stage < recs[best].stage ||
                (recs[i].stage == recs[best].stage && recs[i].pipe > recs[best].pipe))
              best = i;
          end
        end
      end
      if (best >= 0) begin
        if (recs[best].lat <= recs[best].stage) begin
          exp_hit[o]   = 1'b1;
          exp_pipe[o]  = recs[best].pipe;
          exp_stage[o] = recs[best].stage;
        end else begin
          exp_stall = 1'b1;
        end
      end
    end
  endfunction

  function automatic void model_step();
    rec_t nq[$];
    rec_t r;
    model_eval();
    if (exp_stall && m_cnt < CNT_MAX) m_cnt++;
    foreach (recs[i]) begin
      if (!(bus.flush && recs[i].stage <= 2) && recs[i].stage < DEPTH) begin
        r = recs[i];
        r.stage++;
        nq.push_back(r);
      end
    end
    for (int p = 0; p < NUM_PIPES; p++) begin
      if (bus.issue_valid[p] && bus.issue_wr[p] && !exp_stall && !bus.flush) begin
        r.pipe  = p;
        r.dst   = int'(bus.issue_dst[p*REG_AW +: REG_AW]);
        r.lat   = int'(bus.issue_lat[p*LAT_W +: LAT_W]);
        r.stage = 1;
        nq.push_back(r);
      end
    end
    recs = nq;
  endfunction

  function automatic void model_reset();
    recs.delete();
    m_cnt = 0;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic idle();
    bus.issue_valid = '0;
    bus.issue_wr    = '0;
    bus.issue_dst   = '0;
    bus.issue_lat   = '0;
    bus.src_valid   = '0;
    bus.src_reg     = '0;
    bus.flush       = 1'b0;
  endtask

  task automatic set_issue(input int p, input int dst, input int lat);
    bus.issue_valid[p]                 = 1'b1;
    bus.issue_wr[p]                    = 1'b1;
    bus.issue_dst[p*REG_AW +: REG_AW]  = REG_AW'(dst);
    bus.issue_lat[p*LAT_W +: LAT_W]    = LAT_W'(lat);
  endtask

  task automatic set_src(input int o, input int r);
    bus.src_valid[o]                = 1'b1;
    bus.src_reg[o*REG_AW +: REG_AW] = REG_AW'(r);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic drain();
    idle();
    repeat (DEPTH + 1) tick();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset_n = 1'b0;
    idle();
    set_src(0, 5);
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (bus.fwd_hit !== '0 || bus.fwd_pipe !== '0 || bus.fwd_stage !== '0) begin
      n_fail++;
      $display("FAIL reset_fwd: hit=%b pipe=%b stage=%b want all zero", bus.fwd_hit, bus.fwd_pipe, bus.fwd_stage);
    end
    n_checks++;
    if (bus.stall !== 1'b0 || bus.stall_cnt !== '0) begin
      n_fail++;
      $display("FAIL reset_stall: stall=%b cnt=%0d want 0/0", bus.stall, bus.stall_cnt);
    end
    reset_n = 1'b1;
    idle();
    tick();
  endtask

  task automatic test_basic_forward();
    idle();
    set_issue(0, 5, 2);
    tick();
    idle();
    set_src(0, 5);
    @(negedge clk);
    n_checks++;
    if (bus.stall !== 1'b1 || bus.fwd_hit[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_t1: stall=%b hit=%b want 1/0", bus.stall, bus.fwd_hit[0]);
    end
    tick();
    @(negedge clk);
    n_checks++;
    if (bus.fwd_hit[0] !== 1'b1 || bus.fwd_pipe[0*PW +: PW] !== PW'(0) ||
        bus.fwd_stage[0*SW +: SW] !== SW'(2) || bus.stall !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_t2: hit=%b pipe=%0d stage=%0d stall=%b want 1/0/2/0",
               bus.fwd_hit[0], bus.fwd_pipe[0*PW +: PW], bus.fwd_stage[0*SW +: SW], bus.stall);
    end
    n_checks++;
    if (bus.stall_cnt !== CNT_W'(1)) begin
      n_fail++;
      $display("FAIL basic_cnt: got %0d want 1", bus.stall_cnt);
    end
    drain();
  endtask

  task automatic test_youngest_wins();
    idle();
    set_issue(0, 9, 1);
    tick();
    idle();
    set_issue(1, 9, 6);
    tick();
    idle();
    tick();
    set_src(3, 9);
    @(negedge clk);
    n_checks++;
    if (bus.stall !== 1'b1 || bus.fwd_hit[3] !== 1'b0) begin
      n_fail++;
      $display("FAIL youngest: stall=%b hit=%b want 1/0", bus.stall, bus.fwd_hit[3]);
    end
    drain();
  endtask

  task automatic test_same_stage();
    idle();
    set_issue(0, 12, 1);
    set_issue(1, 12, 1);
    tick();
    idle();
    set_src(0, 12);
    @(negedge clk);
    n_checks++;
    if (bus.fwd_hit[0] !== 1'b1 || bus.fwd_pipe[0*PW +: PW] !== PW'(1) ||
        bus.fwd_stage[0*SW +: SW] !== SW'(1) || bus.stall !== 1'b0) begin
      n_fail++;
      $display("FAIL same_stage: hit=%b pipe=%0d stage=%0d stall=%b want 1/1/1/0",
               bus.fwd_hit[0], bus.fwd_pipe[0*PW +: PW], bus.fwd_stage[0*SW +: SW], bus.stall);
    end
    drain();
  endtask

  task automatic test_retire();
    idle();
    set_issue(0, 20, 4);
    tick();
    idle();
    set_src(1, 20);
    for (int t = 1; t <= 8; t++) begin
      @(negedge clk);
      n_checks++;
      if (t < 4) begin
        if (bus.stall !== 1'b1 || bus.fwd_hit[1] !== 1'b0) begin
          n_fail++;
          $display("FAIL retire_t%0d: stall=%b hit=%b want 1/0", t, bus.stall, bus.fwd_hit[1]);
        end
      end else if (t <= DEPTH) begin
        if (bus.stall !== 1'b0 || bus.fwd_hit[1] !== 1'b1 || bus.fwd_stage[1*SW +: SW] !== SW'(t)) begin
          n_fail++;
          $display("FAIL retire_t%0d: stall=%b hit=%b stage=%0d want 0/1/%0d",
                   t, bus.stall, bus.fwd_hit[1], bus.fwd_stage[1*SW +: SW], t);
        end
      end else begin
        if (bus.stall !== 1'b0 || bus.fwd_hit[1] !== 1'b0 || bus.fwd_stage[1*SW +: SW] !== SW'(0)) begin
          n_fail++;
          $display("FAIL retire_t%0d: stall=%b hit=%b stage=%0d want 0/0/0",
                   t, bus.stall, bus.fwd_hit[1], bus.fwd_stage[1*SW +: SW]);
        end
      end
      tick();
    end
    drain();
  endtask

  task automatic test_bubble_flush();
    idle();
    set_issue(0, 40, 7);
    tick();
    for (int t = 1; t <= 3; t++) begin
      idle();
      set_src(0, 40);
      set_issue(1, 30, 1);
      @(negedge clk);
      n_checks++;
      if (bus.stall !== 1'b1) begin
        n_fail++;
        $display("FAIL bubble_stall_t%0d: stall=%b want 1", t, bus.stall);
      end
      tick();
    end
    for (int t = 4; t <= 5; t++) begin
      idle();
      set_src(4, 30);
      @(negedge clk);
      n_checks++;
      if (bus.fwd_hit[4] !== 1'b0 || bus.stall !== 1'b0) begin
        n_fail++;
        $display("FAIL bubble_r30_t%0d: hit=%b stall=%b want 0/0", t, bus.fwd_hit[4], bus.stall);
      end
      tick();
    end
    drain();
    set_issue(0, 50, 1);
    tick();
    idle();
    set_issue(0, 51, 1);
    tick();
    idle();
    set_issue(0, 52, 1);
    tick();
    idle();
    set_src(0, 50);
    set_src(1, 51);
    set_src(2, 52);
    @(negedge clk);
    n_checks++;
    if (bus.fwd_hit[0:2] !== 3'b111 || bus.fwd_stage[0*SW +: SW] !== SW'(3) ||
        bus.fwd_stage[1*SW +: SW] !== SW'(2) || bus.fwd_stage[2*SW +: SW] !== SW'(1)) begin
      n_fail++;
      $display("FAIL preflush: hit=%b stages=%b want 111 / 3,2,1", bus.fwd_hit[0:2], bus.fwd_stage[0:3*SW-1]);
    end
    bus.flush = 1'b1;
    set_issue(1, 53, 1);
    tick();
    idle();
    set_src(0, 50);
    set_src(1, 51);
    set_src(2, 52);
    set_src(3, 53);
    @(negedge clk);
    n_checks++;
    if (bus.fwd_hit[0:3] !== 4'b1000 || bus.fwd_stage[0*SW +: SW] !== SW'(4) || bus.stall !== 1'b0) begin
      n_fail++;
      $display("FAIL postflush: hit=%b stage0=%0d stall=%b want 1000/4/0",
               bus.fwd_hit[0:3], bus.fwd_stage[0*SW +: SW], bus.stall);
    end
    drain();
  endtask

  task automatic test_random();
    int errs;
    for (int c = 0; c < 800; c++) begin
      idle();
      for (int p = 0; p < NUM_PIPES; p++) begin
        bus.issue_valid[p] = 1'($urandom_range(0, 1));
        bus.issue_wr[p]    = ($urandom_range(0, 4) != 0);
        bus.issue_dst[p*REG_AW +: REG_AW] = REG_AW'($urandom_range(0, 7));
        bus.issue_lat[p*LAT_W +: LAT_W]   = LAT_W'($urandom_range(0, 9));
      end
      for (int o = 0; o < NOP; o++) begin
        bus.src_valid[o] = ($urandom_range(0, 9) < 7);
        bus.src_reg[o*REG_AW +: REG_AW] = REG_AW'($urandom_range(0, 7));
      end
      bus.flush = ($urandom_range(0, 15) == 0);
      @(negedge clk);
      model_eval();
      errs = 0;
      for (int o = 0; o < NOP; o++) begin
        if (bus.fwd_hit[o] !== exp_hit[o] || bus.fwd_pipe[o*PW +: PW] !== PW'(exp_pipe[o]) ||
            bus.fwd_stage[o*SW +: SW] !== SW'(exp_stage[o])) begin
          errs++;
          $display("FAIL random_op%0d cycle %0d: hit=%b pipe=%0d stage=%0d want %b/%0d/%0d", o, c,
                   bus.fwd_hit[o], bus.fwd_pipe[o*PW +: PW], bus.fwd_stage[o*SW +: SW],
                   exp_hit[o], exp_pipe[o], exp_stage[o]);
        end
      end
      if (bus.stall !== exp_stall || bus.stall_cnt !== CNT_W'(m_cnt)) begin
        errs++;
        $display("FAIL random_stall cycle %0d: stall=%b cnt=%0d want %b/%0d",
                 c, bus.stall, bus.stall_cnt, exp_stall, m_cnt);
      end
      n_checks++;
      if (errs != 0) n_fail++;
      tick();
    end
    drain();
  endtask

  task automatic test_saturation_and_reset();
    int stall_seen;
    int cyc;
    stall_seen = 0;
    cyc = 0;
    while (stall_seen < (1 << CNT_W) + 3 && cyc < 4000) begin
      idle();
      set_src(0, 1);
      set_issue(0, 1, 15);
      @(negedge clk);
      model_eval();
      if (exp_stall) stall_seen++;
      cyc++;
      tick();
    end
    n_checks++;
    if (cyc >= 4000) begin
      n_fail++;
      $display("FAIL sat_budget: saw %0d stall cycles want %0d", stall_seen, (1 << CNT_W) + 3);
    end
    @(negedge clk);
    n_checks++;
    if (bus.stall_cnt !== {CNT_W{1'b1}}) begin
      n_fail++;
      $display("FAIL sat_cnt: got %0d want %0d", bus.stall_cnt, CNT_MAX);
    end
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if (bus.stall_cnt !== '0 || bus.fwd_hit !== '0 || bus.stall !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: cnt=%0d hit=%b stall=%b want 0/0/0", bus.stall_cnt, bus.fwd_hit, bus.stall);
    end
    @(negedge clk);
    reset_n = 1'b1;
    idle();
    tick();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    n_checks = 0;
    n_fail   = 0;
    m_cnt    = 0;
    reset_n  = 1'b0;
    idle();
    test_reset();
    test_basic_forward();
    test_youngest_wins();
    test_same_stage();
    test_retire();
    test_bubble_flush();
    test_random();
    test_saturation_and_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
